// File: rtl/reduce_pkg.sv
// Shared encodings and helpers for the chunked reduction sequencer.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package reduce_pkg;

  localparam logic [1:0] REDUCE_AND  = 2'b00;
  localparam logic [1:0] REDUCE_OR   = 2'b01;
  localparam logic [1:0] REDUCE_XOR  = 2'b10;
  localparam logic [1:0] REDUCE_NAND = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } reduceState_t;

  // Value that leaves the running reduction unchanged: 1 for the AND family, 0 otherwise.
  function automatic logic reduceIdentity(input logic [1:0] op);
    return (op == REDUCE_AND) || (op == REDUCE_NAND);
  endfunction

endpackage

// File: rtl/chunk_reduce.sv
// Combinational CHUNK_WIDTH-bit reducer, seeded with the running accumulator.
// Latency: zero cycles (pure combinational chain).
// Backpressure: none; the caller decides when accOut is registered.
module chunk_reduce
  import reduce_pkg::*;
#(
  parameter int CHUNK_WIDTH = 4
) (
  input  logic [CHUNK_WIDTH-1:0] chunkData,
  input  logic [1:0]             opSel,
  input  logic                   accIn,
  output logic                   accOut
);

  // NAND accumulates as AND; the final inversion happens at the result port.
  logic [CHUNK_WIDTH:0] chain;

  assign chain[0] = accIn;

  for (genvar g = 0; g < CHUNK_WIDTH; g++) begin : gCell
    // One 2-input cell per chunk bit, folding it into the running value.
    always_comb begin
      chain[g+1] = chain[g] & chunkData[g];
      case (opSel)
        REDUCE_OR:  chain[g+1] = chain[g] | chunkData[g];
        REDUCE_XOR: chain[g+1] = chain[g] ^ chunkData[g];
        default:    chain[g+1] = chain[g] & chunkData[g];
      endcase
    end
  end

  assign accOut = chain[CHUNK_WIDTH];

endmodule

// File: rtl/reduce_sequencer.sv
// Reduces a DATA_WIDTH vector to one bit (AND/OR/XOR/NAND), one CHUNK_WIDTH slice per clock.
// Latency: NUM_CHUNKS cycles from accept to outValid (1..NUM_CHUNKS with REDUCE_EARLY_EXIT_EN).
// Backpressure: result held in DONE until outReady; inReady low through RUN and DONE.
module reduce_sequencer
  import reduce_pkg::*;
#(
  parameter int DATA_WIDTH  = 16,
  parameter int CHUNK_WIDTH = 4
) (
  input  logic                  clock,
  input  logic                  resetN,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [DATA_WIDTH-1:0] inputData,
  input  logic [1:0]            opSel,
  output logic                  outValid,
  input  logic                  outReady,
  output logic                  outputData,
  output logic                  busy
);

  localparam int NUM_CHUNKS = (DATA_WIDTH + CHUNK_WIDTH - 1) / CHUNK_WIDTH;
  localparam int CNT_W      = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;
  localparam int PADDED_W   = NUM_CHUNKS * CHUNK_WIDTH;

  reduceState_t          state;
  reduceState_t          stateNext;
  logic [CNT_W-1:0]      chunkCnt;
  logic [DATA_WIDTH-1:0] dataReg;
  logic [1:0]            opReg;
  logic                  acc;
  logic                  accNext;
  logic                  identBit;
  logic                  lastChunk;
  logic                  earlyExit;
  logic [PADDED_W-1:0]   padded;
  logic [CHUNK_WIDTH-1:0] chunkArr [NUM_CHUNKS];
  logic [CHUNK_WIDTH-1:0] curChunk;

  assign identBit = reduceIdentity(opReg);

  // Bits past DATA_WIDTH take the identity so a short final chunk cannot disturb the result.
  for (genvar g = 0; g < PADDED_W; g++) begin : gPad
    if (g < DATA_WIDTH) begin : gData
      assign padded[g] = dataReg[g];
    end else begin : gFill
      assign padded[g] = identBit;
    end
  end

  for (genvar c = 0; c < NUM_CHUNKS; c++) begin : gChunk
    assign chunkArr[c] = padded[c*CHUNK_WIDTH +: CHUNK_WIDTH];
  end

  assign curChunk  = chunkArr[chunkCnt];
  assign lastChunk = (chunkCnt == CNT_W'(NUM_CHUNKS - 1));

  chunk_reduce #(
    .CHUNK_WIDTH(CHUNK_WIDTH)
  ) uChunkReduce (
    .chunkData(curChunk),
    .opSel    (opReg),
    .accIn    (acc),
    .accOut   (accNext)
  );

`ifdef REDUCE_EARLY_EXIT_EN
  // Once AND/NAND hits 0 or OR hits 1 the remaining chunks cannot change the answer.
  assign earlyExit = ((opReg == REDUCE_AND || opReg == REDUCE_NAND) && !accNext) ||
                     ((opReg == REDUCE_OR) && accNext);
`else
  assign earlyExit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state <= IDLE;
    end else begin
      state <= stateNext;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    stateNext = state;
    inReady   = 1'b0;
    outValid  = 1'b0;
    busy      = 1'b0;
    case (state)
      IDLE: begin
        inReady = 1'b1;
        if (inValid) stateNext = RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (lastChunk || earlyExit) stateNext = DONE;
      end
      DONE: begin
        busy     = 1'b1;
        outValid = 1'b1;
        if (outReady) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  // Capture on accept, then fold one chunk per cycle while running.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      acc      <= 1'b0;
      chunkCnt <= '0;
      dataReg  <= '0;
      opReg    <= REDUCE_AND;
    end else begin
      case (state)
        IDLE: begin
          if (inValid) begin
            dataReg  <= inputData;
            opReg    <= opSel;
            acc      <= reduceIdentity(opSel);
            chunkCnt <= '0;
          end
        end
        RUN: begin
          acc      <= accNext;
          chunkCnt <= chunkCnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign outputData = (state == DONE) ? (acc ^ (opReg == REDUCE_NAND)) : 1'b0;

endmodule

// File: tb/tb_reduce_sequencer.sv
module tb_reduce_sequencer;

  logic       clock = 1'b0;
  logic       resetN;
  logic       inValid;
  logic       inReady;
  logic [7:0] inputData;
  logic [1:0] opSel;
  logic       outValid;
  logic       outReady;
  logic       outputData;
  logic       busy;

  int passCount  = 0;
  int checkCount = 0;

  logic expQ[$];
  int   latQ[$];

  always #5 clock = ~clock;

  reduce_sequencer #(.DATA_WIDTH(8), .CHUNK_WIDTH(3)) dut (
    .clock     (clock),
    .resetN    (resetN),
    .inValid   (inValid),
    .inReady   (inReady),
    .inputData (inputData),
    .opSel     (opSel),
    .outValid  (outValid),
    .outReady  (outReady),
    .outputData(outputData),
    .busy      (busy)
  );

  function automatic logic modelResult(input logic [7:0] d, input logic [1:0] op);
    case (op)
      2'b00:   return &d;
      2'b01:   return |d;
      2'b10:   return ^d;
      default: return ~&d;
    endcase
  endfunction

  function automatic int modelLatency(input logic [7:0] d, input logic [1:0] op);
`ifdef REDUCE_EARLY_EXIT_EN
    logic a;
    logic v;
    logic andFam;
    andFam = (op == 2'b00) || (op == 2'b11);
    a = andFam;
    for (int c = 0; c < 3; c++) begin
      for (int b = 0; b < 3; b++) begin
        v = (c*3 + b < 8) ? d[c*3 + b] : andFam;
        if (andFam) a = a & v;
        else if (op == 2'b01) a = a | v;
        else a = a ^ v;
      end
      if (andFam && !a) return c + 1;
      if (op == 2'b01 && a) return c + 1;
    end
    return 3;
`else
    if (d === 8'hxx && op === 2'bxx) return 0;
    return 3;
`endif
  endfunction

  // Present one request, confirm it is accepted, push its expectation.
  task automatic send(input logic [7:0] d, input logic [1:0] op);
    @(negedge clock);
    checkCount++;
    if (inReady !== 1'b1) $display("FAIL send_inReady got=%b want=1", inReady);
    else passCount++;
    inValid = 1'b1; inputData = d; opSel = op;
    @(negedge clock);
    inValid = 1'b0; inputData = 8'($urandom); opSel = 2'($urandom);
    expQ.push_back(modelResult(d, op));
    latQ.push_back(modelLatency(d, op));
    checkCount++;
    if (busy !== 1'b1 || inReady !== 1'b0)
      $display("FAIL run_flags busy=%b inReady=%b want busy=1 inReady=0", busy, inReady);
    else passCount++;
  endtask

  // Wait for the result, check latency and value; optionally stall before taking it.
  task automatic collect(input int stall);
    int   n;
    logic e;
    int   l;
    n = 0;
    while (outValid !== 1'b1 && n < 50) begin
      @(negedge clock);
      n++;
    end
    e = expQ.pop_front();
    l = latQ.pop_front();
    checkCount++;
    if (n !== l) $display("FAIL latency got=%0d want=%0d", n, l);
    else passCount++;
    checkCount++;
    if (outputData !== e) $display("FAIL result got=%b want=%b", outputData, e);
    else passCount++;
    for (int i = 0; i < stall; i++) begin
      outReady = 1'b0;
      @(negedge clock);
      checkCount++;
      if (outValid !== 1'b1 || outputData !== e || inReady !== 1'b0)
        $display("FAIL stall_hold cyc=%0d outValid=%b data=%b inReady=%b want 1/%b/0",
                 i, outValid, outputData, inReady, e);
      else passCount++;
    end
    outReady = 1'b1;
    @(negedge clock);
    outReady = 1'b0;
    checkCount++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL handshake outValid=%b inReady=%b busy=%b want 0/1/0", outValid, inReady, busy);
    else passCount++;
  endtask

  task automatic test_reset();
    resetN = 1'b0; inValid = 1'b0; inputData = '0; opSel = '0; outReady = 1'b0;
    #12;
    checkCount++;
    if (inReady !== 1'b1 || outValid !== 1'b0 || outputData !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_state inReady=%b outValid=%b data=%b busy=%b want 1/0/0/0",
               inReady, outValid, outputData, busy);
    else passCount++;
    @(negedge clock);
    resetN = 1'b1;
  endtask

  task automatic test_and();
    send(8'hFF, 2'b00); collect(0);
    // outReady high while running must not disturb the operation
    outReady = 1'b1;
    send(8'hFB, 2'b00);
    outReady = 1'b0;
    collect(0);
  endtask

  task automatic test_or();
    send(8'h80, 2'b01); collect(0);
    send(8'h00, 2'b01); collect(0);
  endtask

  task automatic test_xor_nand();
    send(8'hB5, 2'b10); collect(0);
    send(8'hB5, 2'b11); collect(0);
    send(8'hFF, 2'b10); collect(0);
    send(8'hFF, 2'b11); collect(0);
  endtask

  task automatic test_backpressure();
    send(8'h5A, 2'b10); collect(10);
  endtask

  task automatic test_reset_mid_run();
    send(8'hFF, 2'b00);
    @(negedge clock);
    resetN = 1'b0;
    #1;
    checkCount++;
    if (outValid !== 1'b0 || inReady !== 1'b1 || busy !== 1'b0)
      $display("FAIL reset_mid_run outValid=%b inReady=%b busy=%b want 0/1/0", outValid, inReady, busy);
    else passCount++;
    void'(expQ.pop_front());
    void'(latQ.pop_front());
    @(negedge clock);
    resetN = 1'b1;
    repeat (4) @(negedge clock);
    checkCount++;
    if (outValid !== 1'b0) $display("FAIL discarded_result outValid=%b want=0", outValid);
    else passCount++;
    send(8'h07, 2'b01); collect(0);
  endtask

  task automatic test_early_exit();
    send(8'hFE, 2'b00); collect(0);
    send(8'hB5, 2'b11); collect(0);
    send(8'h01, 2'b01); collect(0);
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 6; i++) begin
      send(8'($urandom), 2'($urandom));
      collect(i % 3);
    end
  endtask

  initial begin
    test_reset();
    test_and();
    test_or();
    test_xor_nand();
    test_backpressure();
    test_reset_mid_run();
    test_early_exit();
    test_back_to_back();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
